deser400_symbol_decoder: RTL

// - Consumes the 1 bit/clock recovered stream (serout of the 16:1 phase selector) in the CLK400 domain.
// - NRZI-decodes it, hunts for J/K start delimiter, frames 5-bit symbols, decodes 4b/5b (FDDI table).
// - Emits one data nibble or control code per symbol with a 1-cycle strobe; tracks lock and code errors.

---
 rtl/deser400_symbol_decoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/deser400_symbol_decoder.sv
// -----------------------------------------------------------------------------
// deser400_symbol_decoder
//
// Purpose:
//   Takes the 1 bit/clock recovered stream in the CLK400 domain and NRZI-decodes
//   it, where a line transition means 1. In HUNT it searches for the J/K start
//   delimiter. Once found, it frames 5-bit symbols and decodes them with the
//   FDDI 4b/5b table. Each symbol produces one valid strobe carrying the data
//   nibble or control code. An invalid code produces a symerr strobe instead.
//   MAXERR consecutive invalid symbols drop the decoder back to HUNT.
//
// Parameters:
//   MAXERR    consecutive invalid symbols in LOCKED that force HUNT (1..15)
//
// Ports:
//   CLK400    in   1   bit clock
//   reset     in   1   asynchronous, active-high
//   serin     in   1   recovered serial bit (NRZI line coding)
//   err_clr   in   1   synchronous clear of err_count
//   dout      out  4   decoded nibble (data) or control code (kchar=1)
//   kchar     out  1   dout is a control code
//   valid     out  1   one-cycle strobe: dout/kchar valid
//   symerr    out  1   one-cycle strobe: invalid symbol while LOCKED
//   locked    out  1   high in LOCKED
//   err_count out  16  saturating invalid-symbol count
//
// Optional feature (macro DESER_ERRCNT_EN):
//   When defined, err_count counts symerr strobes and saturates at 16'hFFFF.
//   err_clr clears the count on the next edge and wins over a simultaneous
//   symerr.
//   When undefined, err_count is tied to 0 and err_clr is ignored.
// -----------------------------------------------------------------------------
module deser400_symbol_decoder #(
    parameter int MAXERR = 4
) (
    input  logic        CLK400,
    input  logic        reset,
    input  logic        serin,
    input  logic        err_clr,
    output logic [3:0]  dout,
    output logic        kchar,
    output logic        valid,
    output logic        symerr,
    output logic        locked,
    output logic [15:0] err_count
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // J (11000) followed by K (10001); the oldest bit sits in the MSB
    localparam logic [9:0] JK_PATTERN = 10'b11000_10001;
    localparam logic [3:0] MAXERR_C   = 4'(MAXERR);

    // Result is {ok, kchar, nibble}; ok=0 marks an invalid code
    function automatic logic [5:0] decode_4b5b(input logic [4:0] sym);
        logic [5:0] res;
        case (sym)
            5'b11110: res = {1'b1, 1'b0, 4'h0};
            5'b01001: res = {1'b1, 1'b0, 4'h1};
            5'b10100: res = {1'b1, 1'b0, 4'h2};
            5'b10101: res = {1'b1, 1'b0, 4'h3};
            5'b01010: res = {1'b1, 1'b0, 4'h4};
            5'b01011: res = {1'b1, 1'b0, 4'h5};
            5'b01110: res = {1'b1, 1'b0, 4'h6};
            5'b01111: res = {1'b1, 1'b0, 4'h7};
            5'b10010: res = {1'b1, 1'b0, 4'h8};
            5'b10011: res = {1'b1, 1'b0, 4'h9};
            5'b10110: res = {1'b1, 1'b0, 4'hA};
            5'b10111: res = {1'b1, 1'b0, 4'hB};
            5'b11010: res = {1'b1, 1'b0, 4'hC};
            5'b11011: res = {1'b1, 1'b0, 4'hD};
            5'b11100: res = {1'b1, 1'b0, 4'hE};
            5'b11101: res = {1'b1, 1'b0, 4'hF};
            5'b11111: res = {1'b1, 1'b1, 4'h0};   // I
            5'b11000: res = {1'b1, 1'b1, 4'h1};   // J
            5'b10001: res = {1'b1, 1'b1, 4'h2};   // K
            5'b01101: res = {1'b1, 1'b1, 4'h3};   // T
            5'b00111: res = {1'b1, 1'b1, 4'h4};   // R
            5'b11001: res = {1'b1, 1'b1, 4'h5};   // S
            5'b00100: res = {1'b1, 1'b1, 4'h6};   // H
            default:  res = 6'b000000;           // Q and unassigned codes
        endcase
        return res;
    endfunction

    state_t      state_r;
    logic        serin_r;
    logic [9:0]  sr_r;
    logic [2:0]  cnt_r;
    logic [3:0]  errrun_r;
    logic        bit_s;
    logic [5:0]  dec_s;
    logic [4:0]  errrun_inc_s;

    assign bit_s        = serin ^ serin_r;
    assign dec_s        = decode_4b5b(sr_r[4:0]);
    assign errrun_inc_s = {1'b0, errrun_r} + 5'd1;

    // NRZI decode, bit shifter, HUNT/LOCKED framing and registered symbol outputs
    always_ff @(posedge CLK400 or posedge reset) begin
        if (reset) begin
            state_r  <= ST_HUNT;
            serin_r  <= 1'b0;
            sr_r     <= 10'd0;
            cnt_r    <= 3'd0;
            errrun_r <= 4'd0;
            dout     <= 4'd0;
            kchar    <= 1'b0;
            valid    <= 1'b0;
            symerr   <= 1'b0;
            locked   <= 1'b0;
        end else begin
            serin_r <= serin;
            sr_r    <= {sr_r[8:0], bit_s};
            valid   <= 1'b0;
            symerr  <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    if (sr_r == JK_PATTERN) begin
                        state_r  <= ST_LOCKED;
                        locked   <= 1'b1;
                        cnt_r    <= 3'd0;
                        errrun_r <= 4'd0;
                    end else begin
                        state_r  <= ST_HUNT;
                        locked   <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    // cnt==4 means sr_r[4:0] holds a whole symbol
                    if (cnt_r == 3'd4) begin
                        cnt_r <= 3'd0;
                        if (dec_s[5]) begin
                            valid    <= 1'b1;
                            kchar    <= dec_s[4];
                            dout     <= dec_s[3:0];
                            errrun_r <= 4'd0;
                        end else begin
                            // dout/kchar keep the last good symbol
                            symerr <= 1'b1;
                            if (errrun_inc_s >= {1'b0, MAXERR_C}) begin
                                errrun_r <= MAXERR_C;
                                state_r  <= ST_HUNT;
                                locked   <= 1'b0;
                            end else begin
                                errrun_r <= errrun_inc_s[3:0];
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DESER_ERRCNT_EN
    // Saturating count of symerr strobes; a clear wins over a coincident error
    always_ff @(posedge CLK400 or posedge reset) begin
        if (reset) begin
            err_count <= 16'h0000;
        end else if (err_clr) begin
            err_count <= 16'h0000;
        end else if (symerr && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end else begin
            err_count <= err_count;
        end
    end
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign err_count        = 16'h0000;
`endif

endmodule
